// File: rtl/pe_pkg.sv
// Shared types and helpers for the weight-stationary processing element.
// Holds the shadow-weight state enum, default widths and the saturation bounds
// used by pe_mac when PE_SATURATE_EN is defined.
package pe_pkg;

    localparam int unsigned PE_DATA_W_DEF = 8;
    localparam int unsigned PE_ACC_W_DEF  = 24;

    // Shadow weight register occupancy
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } shadow_state_e;

    // Largest signed value representable in acc_w bits
    function automatic logic signed [63:0] sat_max(input int unsigned acc_w);
        return (64'sd1 <<< (acc_w - 32'd1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in acc_w bits
    function automatic logic signed [63:0] sat_min(input int unsigned acc_w);
        return -(64'sd1 <<< (acc_w - 32'd1));
    endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational signed multiply-add: o_sum_c = i_acc + sext(i_a * i_w).
// Build option: PE_SATURATE_EN defined -> result clamps on signed overflow,
// otherwise the sum wraps modulo 2^ACC_W.
// Ports:
//   i_a      DATA_W  activation (signed)
//   i_w      DATA_W  weight (signed)
//   i_acc    ACC_W   incoming partial sum (signed)
//   o_sum_c  ACC_W   combinational result
module pe_mac
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = PE_DATA_W_DEF,
    parameter int unsigned ACC_W  = PE_ACC_W_DEF
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_w,
    input  logic [ACC_W-1:0]  i_acc,
    output logic [ACC_W-1:0]  o_sum_c
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_sum;

    // Full-precision signed product, then sign-extended into the accumulator width
    assign w_prod     = $signed(i_a) * $signed(i_w);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_sum      = $signed(i_acc) + w_prod_ext;

`ifdef PE_SATURATE_EN
    logic w_ovf;

    // Overflow only when both addends share a sign that the sum does not
    assign w_ovf = (i_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                   (w_sum[ACC_W-1] != i_acc[ACC_W-1]);

    always_comb begin
        o_sum_c = w_sum;
        if (w_ovf) begin
            o_sum_c = i_acc[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
        end
    end
`else
    assign o_sum_c = w_sum;
`endif

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with a double-buffered (shadow/active) weight.
// Activations pass left->right, partial sums top->bottom, and weights shift
// top->bottom through the shadow chain while the active weight keeps computing.
// Build option: PE_SATURATE_EN (see pe_mac) selects clamping instead of wrap.
// Ports:
//   clk, reset     clock (rising edge), async active-high reset
//   valid_in       operand strobe for a_in/acc_in
//   a_in, acc_in   activation from left, partial sum from above
//   w_shift, w_in  shift weight chain: shadow <= w_in, w_out <= old shadow
//   w_swap         promote shadow weight to active
//   valid_out, a_out, acc_out   registered datapath outputs (1-cycle latency)
//   w_out          shadow weight forwarded to the PE below
//   w_active_vld   active weight loaded at least once since reset
module pe_ws_dbuf
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = PE_DATA_W_DEF,
    parameter int unsigned ACC_W  = PE_ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [ACC_W-1:0]  acc_in,
    input  logic              w_shift,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_swap,
    output logic              valid_out,
    output logic [DATA_W-1:0] a_out,
    output logic [ACC_W-1:0]  acc_out,
    output logic [DATA_W-1:0] w_out,
    output logic              w_active_vld
);

    shadow_state_e     r_state;
    shadow_state_e     w_state_nxt;
    logic              w_promote;

    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_active;
    logic              r_active_vld;
    logic [DATA_W-1:0] r_w_out;

    logic              r_valid;
    logic [DATA_W-1:0] r_a;
    logic [ACC_W-1:0]  r_acc;

    logic [DATA_W-1:0] w_w_eff;
    logic [ACC_W-1:0]  w_mac_sum;

    // Shadow occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and promote decision; a swap with an empty shadow is ignored
    always_comb begin
        w_state_nxt = r_state;
        w_promote   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_shift) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_swap) begin
                    w_promote   = 1'b1;
                    w_state_nxt = w_shift ? S_FULL : S_EMPTY;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Weight registers: promote and shift both read the pre-edge shadow value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow     <= '0;
            r_active     <= '0;
            r_active_vld <= 1'b0;
            r_w_out      <= '0;
        end else begin
            if (w_shift) begin
                r_shadow <= w_in;
                r_w_out  <= r_shadow;
            end
            if (w_promote) begin
                r_active     <= r_shadow;
                r_active_vld <= 1'b1;
            end
        end
    end

    // Unloaded active weight behaves as zero so partial sums pass through
    assign w_w_eff = r_active_vld ? r_active : '0;

    pe_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .i_a     (a_in),
        .i_w     (w_w_eff),
        .i_acc   (acc_in),
        .o_sum_c (w_mac_sum)
    );

    // Datapath registers; a_out/acc_out hold when no operand is presented
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_acc   <= '0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_a   <= a_in;
                r_acc <= w_mac_sum;
            end
        end
    end

    assign valid_out    = r_valid;
    assign a_out        = r_a;
    assign acc_out      = r_acc;
    assign w_out        = r_w_out;
    assign w_active_vld = r_active_vld;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Self-checking bench for pe_ws_dbuf (DATA_W=8, ACC_W=24).
// Expected MAC results are computed by the bench from the weight it intends
// to be active, pushed at drive time and popped when valid_out appears.
module tb_pe_ws_dbuf;

    typedef struct packed {
        logic [7:0]  a;
        logic [23:0] acc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [7:0]  a_in;
    logic [23:0] acc_in;
    logic        w_shift;
    logic [7:0]  w_in;
    logic        w_swap;
    logic        valid_out;
    logic [7:0]  a_out;
    logic [23:0] acc_out;
    logic [7:0]  w_out;
    logic        w_active_vld;

    int n_vec;
    int n_err;
    exp_t sb[$];

    pe_ws_dbuf #(
        .DATA_W (8),
        .ACC_W  (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .a_in         (a_in),
        .acc_in       (acc_in),
        .w_shift      (w_shift),
        .w_in         (w_in),
        .w_swap       (w_swap),
        .valid_out    (valid_out),
        .a_out        (a_out),
        .acc_out      (acc_out),
        .w_out        (w_out),
        .w_active_vld (w_active_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference MAC: exact integer arithmetic, then wrap or clamp to 24 bits
    function automatic logic [23:0] exp_mac(input int a, input int acc, input int w);
        longint s;
        s = longint'(acc) + longint'(a) * longint'(w);
`ifdef PE_SATURATE_EN
        if (s > 64'sd8388607)  s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
`endif
        return 24'(s);
    endfunction

    // Drive one cycle of inputs; w_exp is the weight the bench expects active
    task automatic step(input logic v, input int a, input int acc,
                        input logic sh, input int win, input logic sw, input int w_exp);
        exp_t e;
        valid_in = v;
        a_in     = 8'(a);
        acc_in   = 24'(acc);
        w_shift  = sh;
        w_in     = 8'(win);
        w_swap   = sw;
        if (v) begin
            e.a   = 8'(a);
            e.acc = exp_mac(a, acc, w_exp);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        w_shift  = 1'b0;
        w_swap   = 1'b0;
    endtask

    // Scoreboard: compare every produced result against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid_out) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 32'(valid_out), 32'd0);
            end else begin
                e = sb.pop_front();
                check("acc_out", 32'(acc_out), 32'(e.acc));
                check("a_out", 32'(a_out), 32'(e.a));
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        valid_in = 1'b0;
        a_in     = '0;
        acc_in   = '0;
        w_shift  = 1'b0;
        w_in     = '0;
        w_swap   = 1'b0;
        #12;
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_acc_out", 32'(acc_out), 32'd0);
        check("rst_w_active_vld", 32'(w_active_vld), 32'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // Swap with empty shadow is ignored; unloaded weight passes acc through
        step(0, 0, 0, 0, 0, 1, 0);
        check("swap_empty_vld", 32'(w_active_vld), 32'd0);
        step(1, 3, 10, 0, 0, 0, 0);
        check("noweight_valid_out", 32'(valid_out), 32'd1);

        // Load 5 and compute 10 + 3*5
        step(0, 0, 0, 1, 5, 0, 0);
        check("w_out_first_shift", 32'(w_out), 32'd0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("load_active_vld", 32'(w_active_vld), 32'd1);
        step(1, 3, 10, 0, 0, 0, 5);
        check("load_valid_out", 32'(valid_out), 32'd1);
        step(0, 0, 0, 0, 0, 0, 5);
        check("idle_valid_out", 32'(valid_out), 32'd0);
        check("idle_acc_hold", 32'(acc_out), 32'd25);
        check("idle_a_hold", 32'(a_out), 32'd3);

        // Signed: w=-4
        step(0, 0, 0, 1, -4, 0, 5);
        step(0, 0, 0, 0, 0, 1, 5);
        step(1, -128, -7, 0, 0, 0, -4);
        step(1, 127, 0, 0, 0, 0, -4);

        // Swap/compute overlap: active 2, shadow 9
        step(0, 0, 0, 1, 2, 0, -4);
        step(0, 0, 0, 0, 0, 1, -4);
        step(0, 0, 0, 1, 9, 0, 2);
        step(1, 1, 0, 0, 0, 1, 2);
        step(1, 1, 0, 0, 0, 0, 9);

        // Chain: shift 11, then shift 22 with swap -> active 11, shadow 22, FULL
        step(0, 0, 0, 1, 11, 0, 9);
        step(0, 0, 0, 1, 22, 1, 9);
        check("chain_w_out", 32'(w_out), 32'd11);
        step(1, 1, 0, 0, 0, 0, 11);
        step(0, 0, 0, 0, 0, 1, 11);
        step(1, 1, 0, 0, 0, 0, 22);
        step(0, 0, 0, 0, 0, 1, 22);
        step(1, 1, 0, 0, 0, 0, 22);

        // Overflow at both ends of the accumulator range, plus a normal case
        step(0, 0, 0, 1, 1, 0, 22);
        check("w_out_after_chain", 32'(w_out), 32'd22);
        step(0, 0, 0, 0, 0, 1, 22);
        step(1, 1, 24'h7FFFFF, 0, 0, 0, 1);
        step(1, -1, -8388608, 0, 0, 0, 1);
        step(1, -1, 5, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Reset mid-stream drops an in-flight operand
        step(0, 0, 0, 1, 7, 0, 1);
        valid_in = 1'b1;
        a_in     = 8'd9;
        acc_in   = 24'd100;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid_out", 32'(valid_out), 32'd0);
        check("mid_rst_acc_out", 32'(acc_out), 32'd0);
        check("mid_rst_a_out", 32'(a_out), 32'd0);
        check("mid_rst_w_out", 32'(w_out), 32'd0);
        check("mid_rst_active_vld", 32'(w_active_vld), 32'd0);
        valid_in = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 1, 0);
        check("post_rst_swap_empty", 32'(w_active_vld), 32'd0);
        step(1, 5, 7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
